cla_seq_adder: RTL
==================

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the request operands are valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have ports a and b, input, W each, the operands.
REQ-007 The block SHALL have port ci, input, 1, the carry-in for add; it is ignored for subtract.
REQ-008 The block SHALL have port sub, input, 1: 0 selects a+b+ci, 1 selects a-b.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have ports sum (output, W, the result), co (output, 1, final carry-out; for subtract 1 means no borrow) and ovf (output, 1, signed overflow).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, in_valid=1 SHALL capture a, b (b inverted when sub=1), carry seed (ci when add; 1 when sub) and clear the slice counter, then move to RUN.
REQ-015 In RUN, each cycle SHALL feed slice k (bits 4k+3..4k) plus the stored carry through one 4-bit CLA, write the 4-bit result into sum slice k, store the carry-out and increment k.
REQ-016 The transition RUN->DONE SHALL occur on the edge that writes slice NIBBLES-1; out_valid SHALL therefore rise exactly NIBBLES cycles after the accepting edge.
REQ-017 On DONE, co SHALL equal the carry-out of the top slice, and ovf SHALL be (a[W-1]==b_eff[W-1]) && (sum[W-1]!=a[W-1]).
REQ-018 In DONE, sum, co and ovf SHALL be held stable while out_ready=0.
REQ-019 DONE with out_ready=1 SHALL return to IDLE on that edge; there is no IDLE bypass, so back-to-back throughput is one result per NIBBLES+2 cycles.
REQ-020 Operand inputs SHALL be ignored outside the IDLE accept edge; changing a/b/sub during RUN SHALL NOT affect the result.
REQ-021 Arithmetic SHALL wrap modulo 2^W, with no saturation.
REQ-022 The slice counter SHALL be ceil(log2(NIBBLES)) bits wide (minimum 1) and SHALL never exceed NIBBLES-1.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, co=0, ovf=0, counter=0 and stored carry=0, regardless of state, including mid-RUN.
REQ-024 No partial result SHALL survive reset, and the first request after deassertion SHALL be accepted normally.

Structure
REQ-025 A shared package cla_seq_pkg SHALL hold the state enumeration (IDLE/RUN/DONE encoding) and the slice width constant (4).
REQ-026 The block SHALL instantiate exactly one sub-module, the existing 4-bit carry-lookahead adder Look_a_head_carry (a, b, ci, sum, co), reused each RUN cycle.
REQ-027 Slice selection SHALL be implemented as a counter-indexed mux, not as NIBBLES adder copies.

Verification
REQ-028 Add: a=0x1234, b=0x4321, ci=0 -> sum=0x5555, co=0, ovf=0; out_valid rises 4 cycles after accept.
REQ-029 Carry ripple: a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, ovf=0.
REQ-030 Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, co=0 (borrow), ovf=0.
REQ-031 Signed overflow: a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1; a=0x8000, b=0x0001 sub -> sum=0x7FFF, ovf=1.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE on the next edge, in_ready=1.
REQ-033 Reset mid-RUN: assert rst after 2 slices -> outputs zero immediately; after release, a=0x0F0F + b=0x00F1 -> sum=0x1000, co=0.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg
// Shared definitions for the sequential carry-lookahead adder:
//   state_t  - controller state encoding (IDLE / RUN / DONE)
//   SLICE_W  - width of one arithmetic slice (one 4-bit CLA pass)
//   cnt_width() - slice counter width for a given slice count (minimum 1)
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // ceil(log2(n)), never below 1 so a single-slice build still has a counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_lookahead.sv
// Look_a_head_carry
// Combinational 4-bit carry-lookahead adder.
// Ports:
//   a, b  - 4-bit addends
//   ci    - carry in
//   sum   - 4-bit sum
//   co    - carry out of bit 3
module Look_a_head_carry
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] sum,
  output logic               co
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of generate/propagate terms,
  // so no carry depends on a lower carry.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_sum
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign co = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder
// Multi-cycle adder/subtractor that pushes a W = 4*NIBBLES bit operation
// through a single 4-bit carry-lookahead slice, one slice per clock.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - request handshake (accepted only in IDLE)
//   a, b                - W-bit operands
//   ci                  - carry in for add (ignored for subtract)
//   sub                 - 0: a+b+ci, 1: a-b
//   out_valid/out_ready - result handshake (result held in DONE)
//   sum, co, ovf        - result, final carry (1 = no borrow on subtract),
//                         signed overflow
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   co,
  output logic                   ovf
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // b already inverted for subtract
  logic [W-1:0]    sum_reg;
  logic            co_reg;
  logic            ovf_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;

  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_co;

  // Counter-indexed operand slice selection feeding the one shared CLA.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (count_reg == CW'(i)) begin
        a_slice = a_reg[i*SLICE_W +: SLICE_W];
        b_slice = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  Look_a_head_carry u_cla (
    .a   (a_slice),
    .b   (b_slice),
    .ci  (carry_reg),
    .sum (slice_sum),
    .co  (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      co_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            // Subtract is a + ~b + 1: invert b here, seed the carry with 1.
            b_reg        <= sub ? ~b : b;
            carry_reg    <= sub ? 1'b1 : ci;
            count_reg    <= '0;
            sum_reg      <= '0;
            co_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (count_reg == CW'(i)) begin
              sum_reg[i*SLICE_W +: SLICE_W] <= slice_sum;
            end
          end
          carry_reg <= slice_co;
          if (count_reg == LAST) begin
            // Top slice: its MSB is sum[W-1], so overflow is known now.
            co_reg        <= slice_co;
            ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) &&
                             (slice_sum[SLICE_W-1] != a_reg[W-1]);
            count_reg     <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          count_reg     <= '0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign co        = co_reg;
  assign ovf       = ovf_reg;

endmodule
